// File: rtl/regfile_sb.sv
// Register file with per-register pending scoreboard; reg 0 reads zero and is never pending.
// Latency: reads, rbusy and iss_ready are combinational; writes, issues and pend_cnt update on the clock edge.
// Backpressure: only iss_ready, and the caller stalls on it; wen is never stalled. REGFILE_BYPASS_EN adds write-through forwarding.
module regfile_sb #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int NREAD     = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREAD*ADDR_BITS-1:0] rn,
    output logic [NREAD*WIDTH-1:0]     ro,
    output logic [NREAD-1:0]           rbusy,
    input  logic                       wen,
    input  logic [ADDR_BITS-1:0]       wregn,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       iss_en,
    input  logic [ADDR_BITS-1:0]       iss_regn,
    output logic                       iss_ready,
    output logic [ADDR_BITS:0]         pend_cnt
);

    localparam int DEPTH = 2**ADDR_BITS;
    localparam logic [ADDR_BITS:0] CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [WIDTH-1:0]     regs [DEPTH];
    logic [DEPTH-1:0]     pending;
    logic [ADDR_BITS-1:0] ra [NREAD];
    logic                 wr_hit;
    logic                 iss_acc;
    logic                 cnt_inc;
    logic                 cnt_dec;

    for (genvar k = 0; k < NREAD; k++) begin : g_ra
        assign ra[k] = rn[k*ADDR_BITS +: ADDR_BITS];
    end

    assign wr_hit = wen && (wregn != '0);

    always_comb begin
        iss_ready = (iss_regn == '0) || !pending[iss_regn];
`ifdef REGFILE_BYPASS_EN
        if (wr_hit && (iss_regn == wregn)) begin
            iss_ready = 1'b1;
        end
`endif
    end

    assign iss_acc = iss_en && iss_ready && (iss_regn != '0);

    // Count moves only on real 0->1 / 1->0 transitions of the pending vector.
    assign cnt_inc = iss_acc && !pending[iss_regn];
    assign cnt_dec = wr_hit && pending[wregn] && !(iss_acc && (iss_regn == wregn));

    always_ff @(posedge clk) begin
        if (reset) begin
            pending  <= '0;
            pend_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wr_hit) begin
                regs[wregn]    <= wdata;
                pending[wregn] <= 1'b0;
            end
            // Issue after write so a same-register set wins over the clear.
            if (iss_acc) begin
                pending[iss_regn] <= 1'b1;
            end
            pending[0] <= 1'b0;
            if (cnt_inc && !cnt_dec) begin
                pend_cnt <= pend_cnt + CNT_ONE;
            end else if (cnt_dec && !cnt_inc) begin
                pend_cnt <= pend_cnt - CNT_ONE;
            end
        end
    end

    always_comb begin
        ro    = '0;
        rbusy = '0;
        for (int k = 0; k < NREAD; k++) begin
            ro[k*WIDTH +: WIDTH] = (ra[k] == '0) ? '0 : regs[ra[k]];
            rbusy[k]             = pending[ra[k]];
`ifdef REGFILE_BYPASS_EN
            if (wr_hit && (ra[k] == wregn)) begin
                ro[k*WIDTH +: WIDTH] = wdata;
                rbusy[k]             = iss_en && (iss_regn == wregn);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (4 read ports) with a spec-level model checked every cycle.
module tb_regfile_sb;

    localparam int W  = 32;
    localparam int AB = 5;
    localparam int NR = 4;

    logic            clk;
    logic            reset;
    logic [NR*AB-1:0] rn;
    logic [NR*W-1:0] ro;
    logic [NR-1:0]   rbusy;
    logic            wen;
    logic [AB-1:0]   wregn;
    logic [W-1:0]    wdata;
    logic            iss_en;
    logic [AB-1:0]   iss_regn;
    logic            iss_ready;
    logic [AB:0]     pend_cnt;

    int passed = 0;
    int total  = 0;
    bit chk_en = 0;

    logic [W-1:0] mreg  [32];
    bit           mpend [32];

    regfile_sb #(.WIDTH(W), .ADDR_BITS(AB), .NREAD(NR)) dut (
        .clk(clk), .reset(reset), .rn(rn), .ro(ro), .rbusy(rbusy),
        .wen(wen), .wregn(wregn), .wdata(wdata),
        .iss_en(iss_en), .iss_regn(iss_regn), .iss_ready(iss_ready),
        .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [AB-1:0] rn_of(input int k);
        return rn[k*AB +: AB];
    endfunction

    function automatic logic [W-1:0] ro_of(input int k);
        return ro[k*W +: W];
    endfunction

    task automatic set_rn(input int k, input int r);
        rn[k*AB +: AB] = AB'(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level model: architectural registers plus a pending flag per register.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                mreg[i]  <= '0;
                mpend[i] <= 1'b0;
            end
        end else begin
            if (wen && wregn != 0) begin
                mreg[wregn]  <= wdata;
                mpend[wregn] <= 1'b0;
            end
            if (iss_en && iss_regn != 0 && exp_ready())
                mpend[iss_regn] <= 1'b1;
        end
    end

    function automatic bit exp_ready();
`ifdef REGFILE_BYPASS_EN
        if (wen && wregn != 0 && wregn == iss_regn) return 1'b1;
`endif
        return (iss_regn == 0) || !mpend[iss_regn];
    endfunction

    function automatic logic [W-1:0] exp_ro(input int k);
        logic [AB-1:0] a;
        a = rn_of(k);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wen && a == wregn) return wdata;
`endif
        return mreg[a];
    endfunction

    function automatic bit exp_busy(input int k);
        logic [AB-1:0] a;
        a = rn_of(k);
`ifdef REGFILE_BYPASS_EN
        if (wen && a != 0 && a == wregn) return iss_en && iss_regn == a;
`endif
        return mpend[a];
    endfunction

    function automatic logic [AB:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mpend[i]);
        return (AB+1)'(n);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NR; k++) begin
                check("cmp_ro", 64'(ro_of(k)), 64'(exp_ro(k)));
                check("cmp_rbusy", 64'(rbusy[k]), 64'(exp_busy(k)));
            end
            check("cmp_iss_ready", 64'(iss_ready), 64'(exp_ready()));
            check("cmp_pend_cnt", 64'(pend_cnt), 64'(exp_cnt()));
        end
    end

    initial begin
        reset = 1'b1; rn = '0; wen = 1'b0; wregn = '0; wdata = '0;
        iss_en = 1'b0; iss_regn = '0;
        tick();
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset state across all registers
        check("rst_pend_cnt", 64'(pend_cnt), 64'd0);
        iss_regn = 5'd5; #1;
        check("rst_iss_ready", 64'(iss_ready), 64'd1);
        for (int i = 0; i < 32; i++) begin
            set_rn(0, i); set_rn(1, 31 - i); #1;
            check("rst_ro0", 64'(ro_of(0)), 64'd0);
            check("rst_ro1", 64'(ro_of(1)), 64'd0);
            check("rst_rbusy", 64'(rbusy), 64'd0);
            tick();
        end

        // Write sweep reg i = i
        for (int i = 1; i < 32; i++) begin
            wen = 1'b1; wregn = AB'(i); wdata = W'(i);
            tick();
        end
        wen = 1'b0;
        set_rn(1, 20); set_rn(0, 10); #1;
        check("sweep_ro1", 64'(ro_of(1)), 64'd20);
        check("sweep_ro0", 64'(ro_of(0)), 64'd10);
        wen = 1'b1; wregn = 5'd0; wdata = 32'hDEADBEEF;
        tick();
        wen = 1'b0; set_rn(0, 0); #1;
        check("reg0_zero", 64'(ro_of(0)), 64'd0);

        // Scoreboard
        iss_en = 1'b1; iss_regn = 5'd5; tick();
        iss_regn = 5'd9; tick();
        iss_en = 1'b0; set_rn(0, 5); #1;
        check("sb_cnt2", 64'(pend_cnt), 64'd2);
        check("sb_busy5", 64'(rbusy[0]), 64'd1);
        iss_en = 1'b1; iss_regn = 5'd5; #1;
        check("sb_not_ready", 64'(iss_ready), 64'd0);
        tick();
        iss_en = 1'b0; #1;
        check("sb_cnt_still2", 64'(pend_cnt), 64'd2);
        wen = 1'b1; wregn = 5'd5; wdata = 32'h55; tick();
        wen = 1'b0; #1;
        check("sb_busy5_clr", 64'(rbusy[0]), 64'd0);
        check("sb_ro5", 64'(ro_of(0)), 64'h55);
        check("sb_cnt1", 64'(pend_cnt), 64'd1);

        // Issue and write the same register
        iss_en = 1'b1; iss_regn = 5'd7; wen = 1'b1; wregn = 5'd7; wdata = 32'h77;
        tick();
        iss_en = 1'b0; wen = 1'b0; set_rn(0, 7); #1;
        check("same_ro7", 64'(ro_of(0)), 64'h77);
        check("same_busy7", 64'(rbusy[0]), 64'd1);
        check("same_cnt2", 64'(pend_cnt), 64'd2);

        // Issue r3 and write r4 together
        iss_en = 1'b1; iss_regn = 5'd3; wen = 1'b1; wregn = 5'd4; wdata = 32'h44;
        tick();
        iss_en = 1'b0; wen = 1'b0; set_rn(0, 3); set_rn(1, 4); #1;
        check("diff_cnt3", 64'(pend_cnt), 64'd3);
        check("diff_busy3", 64'(rbusy[0]), 64'd1);
        check("diff_ro4", 64'(ro_of(1)), 64'h44);
        check("diff_busy4", 64'(rbusy[1]), 64'd0);

        // Same-cycle read of the register being written
        wen = 1'b1; wregn = 5'd12; wdata = 32'hABCD; set_rn(0, 12); #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_cycle", 64'(ro_of(0)), 64'hABCD);
`else
        check("byp_same_cycle", 64'(ro_of(0)), 64'd12);
`endif
        tick();
        wen = 1'b0; #1;
        check("byp_after_edge", 64'(ro_of(0)), 64'hABCD);

        // Reset mid-operation with r3, r7, r9 pending
        check("pre_rst_cnt3", 64'(pend_cnt), 64'd3);
        reset = 1'b1; wen = 1'b1; wregn = 5'd20; wdata = 32'h1234;
        iss_en = 1'b1; iss_regn = 5'd21;
        tick();
        reset = 1'b0; wen = 1'b0; iss_en = 1'b0;
        set_rn(0, 20); set_rn(1, 21); set_rn(2, 9); #1;
        check("mid_rst_cnt0", 64'(pend_cnt), 64'd0);
        check("mid_rst_ro20", 64'(ro_of(0)), 64'd0);
        check("mid_rst_busy21", 64'(rbusy[1]), 64'd0);
        check("mid_rst_busy9", 64'(rbusy[2]), 64'd0);
        check("mid_rst_ready21", 64'(iss_ready), 64'd1);
        wen = 1'b1; wregn = 5'd9; wdata = 32'h99; tick();
        wen = 1'b0; #1;
        check("late_wr_ro9", 64'(ro_of(2)), 64'h99);
        check("late_wr_cnt0", 64'(pend_cnt), 64'd0);

        // Four ports on distinct registers
        for (int i = 1; i <= 4; i++) begin
            wen = 1'b1; wregn = AB'(i + 16); wdata = 32'h1100 * i;
            tick();
        end
        wen = 1'b0;
        for (int k = 0; k < NR; k++) set_rn(k, 20 - k);
        #1;
        check("p4_ro0", 64'(ro_of(0)), 64'h4400);
        check("p4_ro1", 64'(ro_of(1)), 64'h3300);
        check("p4_ro2", 64'(ro_of(2)), 64'h2200);
        check("p4_ro3", 64'(ro_of(3)), 64'h1100);
        tick();
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
